change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Payment-side counterpart to the product price lookup. It accepts a vend request carrying the inserted credit and the looked-up 4-bit price. It decides whether to vend or refund, pulses the item-release output, and then pays out change or the refund one coin at a time over a valid/ready coin interface. It sits between the coin accumulator/price path and the coin hopper driver.

Parameters:
CREDIT_W, 5, width of inserted credit and of the internal remaining-amount register (max credit 2**CREDIT_W-1)
PRICE_W, 4, width of price input; must be <= CREDIT_W

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  vend request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_credit  input  CREDIT_W  inserted credit, sampled on request handshake
req_price  input  PRICE_W  item price, sampled on request handshake; 0 means invalid selection
item_out  output  1  one-cycle pulse: release item
refund  output  1  high from EVAL through DONE when the request is refunded instead of vended
coin_valid  output  1  a coin is offered to the hopper
coin_ready  input  1  hopper accepts the offered coin
coin_code  output  2  offered coin: 2'b01=1, 2'b10=2, 2'b11=5, 2'b00=none
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: transaction complete

Behaviour:
- Reset (async assert, sync deassert to clk by upstream): state=IDLE, remaining=0, refund=0. Outputs: item_out=0, coin_valid=0, coin_code=2'b00, done=0, busy=0, req_ready=1.
- All outputs are decoded from registered state/remaining only; no combinational path from inputs to outputs.
- States: IDLE, EVAL, VEND, CHANGE, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, register credit and price, then go to EVAL.
- EVAL (1 cycle):
  - Compute diff = {1'b0,credit} - {1'b0,zero-extended price} in CREDIT_W+1 bits.
  - If price==0 or diff is negative (borrow): refund=1, remaining=credit.
  - Else: refund=0, remaining=diff[CREDIT_W-1:0].
  - Next state: VEND if vending; else CHANGE if remaining!=0; else DONE.
- VEND (1 cycle): item_out=1. Next state: CHANGE if remaining!=0, else DONE.
- CHANGE:
  - coin_valid=1; coin_code is greedy: 5 if remaining>=5, else 2 if >=2, else 1.
  - On coin_valid&&coin_ready, remaining -= coin value; go to DONE when the new remaining==0, else stay.
  - While coin_ready=0, coin_valid and coin_code hold stable.
  - coin_code is 2'b00 whenever coin_valid=0.
- DONE (1 cycle): done=1, then IDLE. refund clears on entry to IDLE.
- Latency, with the request handshake at edge T:
  - EVAL during cycle T+1.
  - item_out during T+2 (vend only).
  - First coin offered T+3 (vend) or T+2 (refund).
  - Exact price with no change: done during T+3.
- Boundaries:
  - credit==price: vend with zero coins.
  - credit=0 with price=0: refund with zero coins, done at T+2.
  - req_valid held high while busy: ignored, not sampled.
  - Maximum change 31 = six 5-coins then one 1-coin.
- Reset mid-transaction: immediate return to IDLE. The pending coin is abandoned (no partial-payment tracking). item_out/done are not emitted.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, EVAL, VEND, CHANGE, DONE)
  - coin code constants COIN_NONE/COIN_1/COIN_2/COIN_5
  - denomination values 1/2/5
- One natural sub-module: coin_picker. It is purely combinational: remaining -> coin_code and coin value (greedy). It is reused by any future refund path.

Test Plan:
- credit=12, price=7, coin_ready tied 1 -> item_out pulse at T+2; one coin 5 at T+3; done at T+4; refund=0.
- credit=10, price=10 -> item_out at T+2; no coin_valid; done at T+3.
- credit=4, price=5 -> refund=1; no item_out; coins 2,2 at T+2,T+3; done at T+4.
- credit=8, price=0 (invalid selection) -> refund=1; coins 5,2,1; done after third accept.
- credit=31, price=5 with coin_ready low for 3 cycles on the second coin -> coin_code stays 5 and coin_valid stays high while stalled; coins 5x5 then 1; total 26.
- rst_n pulsed low during CHANGE (credit=20, price=5, after first coin) -> all outputs at reset values immediately, req_ready=1; a new request then completes normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: controller states, the coin
// codes driven towards the hopper and the value of each denomination.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    localparam int unsigned DENOM_1 = 1;
    localparam int unsigned DENOM_2 = 2;
    localparam int unsigned DENOM_5 = 5;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selection: for a remaining amount, choose the largest
// denomination that does not exceed it (5, then 2, otherwise 1).
// Purely combinational.
//   amount_i    : amount still to be paid out
//   coin_code_o : code of the selected coin (never COIN_NONE)
//   coin_val_o  : value of the selected coin, same width as amount_i
module coin_picker
    import vend_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] amount_i,
    output logic [1:0]   coin_code_o,
    output logic [W-1:0] coin_val_o
);

    always_comb begin
        coin_code_o = COIN_1;
        coin_val_o  = W'(DENOM_1);
        if (amount_i >= W'(DENOM_5)) begin
            coin_code_o = COIN_5;
            coin_val_o  = W'(DENOM_5);
        end else if (amount_i >= W'(DENOM_2)) begin
            coin_code_o = COIN_2;
            coin_val_o  = W'(DENOM_2);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Vend/refund controller. Accepts a request with inserted credit and item
// price, decides vend or refund, pulses item_out when vending, then pays
// the change (or the full credit on refund) one coin at a time over a
// valid/ready coin interface. All outputs decode registered state only.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_credit, req_price  : sampled on handshake; price 0 = invalid item
//   item_out               : one-cycle release pulse (vend only)
//   refund                 : request is being refunded (EVAL..DONE)
//   coin_valid/coin_ready  : coin offer handshake towards the hopper
//   coin_code              : offered coin, COIN_NONE when not offering
//   busy, done             : not idle / one-cycle completion pulse
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 5,
    parameter int unsigned PRICE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CREDIT_W-1:0] req_credit,
    input  logic [PRICE_W-1:0]  req_price,
    output logic                item_out,
    output logic                refund,
    output logic                coin_valid,
    input  logic                coin_ready,
    output logic [1:0]          coin_code,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [PRICE_W-1:0]  price_q, price_d;
    logic [CREDIT_W-1:0] remain_q, remain_d;
    logic                refund_q, refund_d;

    logic [CREDIT_W:0]   diff;
    logic [1:0]          pick_code;
    logic [CREDIT_W-1:0] pick_val;

    coin_picker #(
        .W (CREDIT_W)
    ) u_picker (
        .amount_i    (remain_q),
        .coin_code_o (pick_code),
        .coin_val_o  (pick_val)
    );

    // One extra bit so that price > credit shows up as a set MSB (borrow).
    assign diff = {1'b0, credit_q} - (CREDIT_W+1)'(price_q);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        remain_d = remain_q;
        refund_d = refund_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    credit_d = req_credit;
                    price_d  = req_price;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (price_q == '0 || diff[CREDIT_W]) begin
                    refund_d = 1'b1;
                    remain_d = credit_q;
                    state_d  = (credit_q != '0) ? ST_CHANGE : ST_DONE;
                end else begin
                    refund_d = 1'b0;
                    remain_d = diff[CREDIT_W-1:0];
                    state_d  = ST_VEND;
                end
            end
            ST_VEND: begin
                state_d = (remain_q != '0) ? ST_CHANGE : ST_DONE;
            end
            ST_CHANGE: begin
                if (coin_ready) begin
                    remain_d = remain_q - pick_val;
                    state_d  = (remain_q == pick_val) ? ST_DONE : ST_CHANGE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                refund_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            remain_q <= '0;
            refund_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            remain_q <= remain_d;
            refund_q <= refund_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign item_out   = (state_q == ST_VEND);
    assign done       = (state_q == ST_DONE);
    assign refund     = refund_q;
    assign coin_valid = (state_q == ST_CHANGE);
    assign coin_code  = coin_valid ? pick_code : COIN_NONE;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam int unsigned CREDIT_W = 5;
    localparam int unsigned PRICE_W  = 4;

    localparam int EV_ITEM = 0;
    localparam int EV_COIN = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int         kind;
        logic [1:0] code;
        int         rel;
        logic       rf;
    } ev_t;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [CREDIT_W-1:0] req_credit;
    logic [PRICE_W-1:0]  req_price;
    logic                item_out;
    logic                refund;
    logic                coin_valid;
    logic                coin_ready;
    logic [1:0]          coin_code;
    logic                busy;
    logic                done;

    change_dispenser #(
        .CREDIT_W (CREDIT_W),
        .PRICE_W  (PRICE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_credit (req_credit),
        .req_price  (req_price),
        .item_out   (item_out),
        .refund     (refund),
        .coin_valid (coin_valid),
        .coin_ready (coin_ready),
        .coin_code  (coin_code),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  hs_cyc  = 0;
    int  acc_idx = 0;
    int  stall_idx  = -1;
    int  stall_left = 0;
    int  paid    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: drives coin_ready for the current cycle, then scores events.
    always @(negedge clk) begin
        ev_t e;
        int  rel;
        coin_ready = 1'b1;
        if (rst_n) begin
            rel = cyc - hs_cyc + 1;
            if (coin_valid && acc_idx == stall_idx && stall_left > 0) begin
                coin_ready = 1'b0;
                stall_left--;
                if (sb.size() > 0) check("stall_code", coin_code, sb[0].code);
            end
            if (busy && !coin_valid) check("code_idle", coin_code, 0);
            if (item_out || (coin_valid && coin_ready) || done) begin
                if (sb.size() == 0) begin
                    check("extra_event", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", item_out ? EV_ITEM : (done ? EV_DONE : EV_COIN), e.kind);
                    check("ev_rel", rel, e.rel);
                    check("ev_refund", refund, e.rf);
                    if (coin_valid) begin
                        check("coin_code", coin_code, e.code);
                        paid += coin_value(coin_code);
                        acc_idx++;
                    end
                end
            end
            if (req_valid && req_ready) hs_cyc = cyc + 1;
        end
    end

    // Expected event sequence for one request, relative to the handshake edge.
    task automatic push_txn(input int credit, input int price, input int sidx, input int sn);
        int   rem, t, i, v;
        logic rf;
        logic [1:0] c;
        ev_t  e;
        rf  = (price == 0) || (price > credit);
        rem = rf ? credit : credit - price;
        t   = 1;
        if (!rf) begin
            t = 2;
            e.kind = EV_ITEM; e.code = 2'b00; e.rel = t; e.rf = 1'b0;
            sb.push_back(e);
        end
        i = 0;
        while (rem > 0) begin
            if (rem >= 5)      begin c = 2'b11; v = 5; end
            else if (rem >= 2) begin c = 2'b10; v = 2; end
            else               begin c = 2'b01; v = 1; end
            t = t + 1 + ((i == sidx) ? sn : 0);
            e.kind = EV_COIN; e.code = c; e.rel = t; e.rf = rf;
            sb.push_back(e);
            rem -= v;
            i++;
        end
        e.kind = EV_DONE; e.code = 2'b00; e.rel = t + 1; e.rf = rf;
        sb.push_back(e);
    endtask

    task automatic start_req(input int credit, input int price, input int sidx, input int sn);
        int k;
        stall_idx  = sidx;
        stall_left = sn;
        acc_idx    = 0;
        paid       = 0;
        push_txn(credit, price, sidx, sn);
        req_credit = CREDIT_W'(credit);
        req_price  = PRICE_W'(price);
        req_valid  = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 50) check("hs_timeout", k, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic run_txn(input int credit, input int price, input int sidx, input int sn,
                           input bit hold);
        int k;
        start_req(credit, price, sidx, sn);
        if (hold) begin
            // keep requesting with different values while busy
            req_credit = ~req_credit;
            req_price  = 4'd1;
        end else begin
            req_valid = 1'b0;
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (hold && done) req_valid = 1'b0;
            if (sb.size() == 0 && !busy) break;
        end
        req_valid = 1'b0;
        check("sb_drain", sb.size(), 0);
        check("paid_total", paid,
              ((price == 0) || (price > credit)) ? credit : credit - price);
        @(posedge clk);
        #2;
        check("idle_busy", busy, 0);
        check("idle_ready", req_ready, 1);
        check("idle_refund", refund, 0);
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_credit = '0;
        req_price  = '0;
        coin_ready = 1'b1;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_item", item_out, 0);
        check("rst_cvalid", coin_valid, 0);
        check("rst_code", coin_code, 0);
        check("rst_done", done, 0);
        check("rst_refund", refund, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        run_txn(12, 7,  -1, 0, 1'b0);
        run_txn(10, 10, -1, 0, 1'b0);
        run_txn(4,  5,  -1, 0, 1'b0);
        run_txn(8,  0,  -1, 0, 1'b0);
        run_txn(31, 5,   1, 3, 1'b0);
        run_txn(0,  0,  -1, 0, 1'b0);
        run_txn(15, 2,  -1, 0, 1'b1);
        run_txn(3,  15, -1, 0, 1'b0);

        // reset during change payout
        start_req(20, 5, -1, 0);
        req_valid = 1'b0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (acc_idx >= 1) break;
        end
        check("mid_acc", acc_idx >= 1, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ready", req_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_cvalid", coin_valid, 0);
        check("mrst_code", coin_code, 0);
        check("mrst_item", item_out, 0);
        check("mrst_done", done, 0);
        check("mrst_refund", refund, 0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_txn(9, 3, -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
